// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: pattern table, FSM encoding, scan payload.
package seg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned VAL_W = 4;
  localparam int unsigned DIG_N = 8;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_HELD  = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [DIG_N-1:0] sel;
    logic [7:0]       seg;
  } scan_in_t;

  // Active-low a..g pattern for each hex value.
  function automatic logic [SEG_W-1:0] seg_pattern(input logic [VAL_W-1:0] v);
    logic [SEG_W-1:0] p;
    case (v)
      4'h0:    p = 7'b0000001;
      4'h1:    p = 7'b1001111;
      4'h2:    p = 7'b0010010;
      4'h3:    p = 7'b0000110;
      4'h4:    p = 7'b1001100;
      4'h5:    p = 7'b0100100;
      4'h6:    p = 7'b0100000;
      4'h7:    p = 7'b0001111;
      4'h8:    p = 7'b0000000;
      4'h9:    p = 7'b0000100;
      4'hA:    p = 7'b0001000;
      4'hB:    p = 7'b1100000;
      4'hC:    p = 7'b0110001;
      4'hD:    p = 7'b1000010;
      4'hE:    p = 7'b0110000;
      default: p = 7'b0111000;
    endcase
    return p;
  endfunction

  // True when exactly one digit enable is driven low.
  function automatic logic sel_single(input logic [DIG_N-1:0] sel);
    return ($countones(~sel) == 1);
  endfunction

  // Index of the low enable bit; meaningful only when sel_single() holds.
  function automatic logic [2:0] sel_index(input logic [DIG_N-1:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < int'(DIG_N); k++) begin
      if (!sel[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_rx_if.sv
// Scanned display bus in, decoded digit state out.
interface seg_scan_rx_if;
  import seg_pkg::*;

  logic [7:0]             i_seg;
  logic [DIG_N-1:0]       i_sel;
  logic [DIG_N*VAL_W-1:0] o_digits;
  logic [DIG_N-1:0]       o_valid;
  logic [DIG_N-1:0]       o_dp;
  logic                   o_upd;
  logic                   o_err;
  logic                   o_frame;

  modport master (
    output i_seg, i_sel,
    input  o_digits, o_valid, o_dp, o_upd, o_err, o_frame
  );

  modport slave (
    input  i_seg, i_sel,
    output o_digits, o_valid, o_dp, o_upd, o_err, o_frame
  );

endinterface

// File: rtl/seg_decode7.sv
// Combinational 7-segment pattern to hex value decoder with legality flag.
module seg_decode7
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] pat_i,
  output logic [VAL_W-1:0] val_c_o,
  output logic             legal_c_o
);

  // Match against all sixteen legal glyphs; no match means illegal.
  always_comb begin
    val_c_o   = '0;
    legal_c_o = 1'b0;
    for (int i = 0; i < (1 << VAL_W); i++) begin
      if (pat_i == seg_pattern(VAL_W'(i))) begin
        val_c_o   = VAL_W'(i);
        legal_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Receiver for a multiplexed 7-segment display: waits for a stable
// digit/segment combination, decodes it and keeps a per-digit image.
module seg_scan_rx
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
  seg_scan_rx_if.slave bus
);

  scan_in_t               r_in_q;
  scan_in_t               r_prev_q;
  scan_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   capture_c;

  logic [DIG_N*VAL_W-1:0] digits_q;
  logic [DIG_N-1:0]       valid_q;
  logic [DIG_N-1:0]       dp_q;
  logic [DIG_N-1:0]       mask_q;
  logic                   upd_q;
  logic                   err_q;
  logic                   frame_q;

  logic                   sel_ok_c;
  logic                   changed_c;
  logic [2:0]             idx_c;
  logic [DIG_N-1:0]       mask_next_c;
  logic [VAL_W-1:0]       dec_val_c;
  logic                   dec_legal_c;

  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYC);

  // Input capture stage plus one-cycle history for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_q   <= '{sel: '1, seg: '1};
      r_prev_q <= '{sel: '1, seg: '1};
    end else begin
      r_in_q   <= '{sel: bus.i_sel, seg: bus.i_seg};
      r_prev_q <= r_in_q;
    end
  end

  seg_decode7 u_dec (
    .pat_i     (r_in_q.seg[7:1]),
    .val_c_o   (dec_val_c),
    .legal_c_o (dec_legal_c)
  );

  // Selection qualifiers and next seen-mask.
  always_comb begin
    sel_ok_c    = sel_single(r_in_q.sel);
    idx_c       = sel_index(r_in_q.sel);
    changed_c   = (r_in_q != r_prev_q);
    mask_next_c = mask_q | (DIG_N'(1) << idx_c);
  end

  // FSM state and dwell counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: restart the dwell on any change, capture once stable.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    if (!sel_ok_c) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (changed_c || (state_q == ST_IDLE)) begin
      state_d = ST_DWELL;
      cnt_d   = CNT_W'(1);
    end else begin
      case (state_q)
        ST_DWELL: begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((cnt_q + CNT_W'(1)) == CNT_TARGET) begin
            capture_c = 1'b1;
            state_d   = ST_HELD;
          end
        end
        ST_HELD: begin
          state_d = ST_HELD;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Digit image, pulses and frame-completion mask updated on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
      valid_q  <= '0;
      dp_q     <= '0;
      mask_q   <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      upd_q   <= capture_c;
      err_q   <= capture_c & ~dec_legal_c;
      frame_q <= 1'b0;
      if (capture_c) begin
        if (dec_legal_c) begin
          digits_q[{idx_c, 2'b00} +: VAL_W] <= dec_val_c;
        end
        valid_q[idx_c] <= dec_legal_c;
        dp_q[idx_c]    <= ~r_in_q.seg[0];
        if (mask_next_c == '1) begin
          frame_q <= 1'b1;
          mask_q  <= '0;
        end else begin
          mask_q  <= mask_next_c;
        end
      end
    end
  end

  assign bus.o_digits = digits_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_dp     = dp_q;
  assign bus.o_upd    = upd_q;
  assign bus.o_err    = err_q;
  assign bus.o_frame  = frame_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed self-checking bench for seg_scan_rx.
module tb_seg_scan_rx;
  import seg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_rx_if bus ();

  seg_scan_rx #(.STABLE_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int edge_n, n_upd, n_err, n_both, n_frame, first_upd, frame_at_upd, nonzero_pre;
  logic [7:0] pats [8];

  task automatic clear_stats();
    edge_n = 0; n_upd = 0; n_err = 0; n_both = 0; n_frame = 0;
    first_upd = -1; frame_at_upd = -1; nonzero_pre = 0;
  endtask

  // Hold one input combination for n clock edges, sampling after each edge.
  task automatic hold(input logic [7:0] sel, input logic [7:0] seg, input int n);
    bus.i_sel = sel;
    bus.i_seg = seg;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_n++;
      if (bus.o_upd) begin
        n_upd++;
        if (first_upd < 0) first_upd = edge_n;
      end
      if (bus.o_err) n_err++;
      if (bus.o_upd && bus.o_err) n_both++;
      if (bus.o_frame) begin
        n_frame++;
        frame_at_upd = n_upd;
      end
      if (first_upd < 0 && (bus.o_digits != 0 || bus.o_valid != 0 || bus.o_dp != 0 ||
                            bus.o_err || bus.o_frame))
        nonzero_pre++;
    end
  endtask

  task automatic do_reset();
    bus.i_sel = 8'hFF;
    bus.i_seg = 8'hFF;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    bus.i_sel = 8'hFF;
    bus.i_seg = 8'hFF;
    rst = 1'b1;
    #2;
    checks++; if (bus.o_digits !== 32'h0) begin errors++; $display("FAIL reset_digits got %h want %h", bus.o_digits, 32'h0); end
    checks++; if (bus.o_valid !== 8'h00) begin errors++; $display("FAIL reset_valid got %h want %h", bus.o_valid, 8'h00); end
    checks++; if (bus.o_dp !== 8'h00) begin errors++; $display("FAIL reset_dp got %h want %h", bus.o_dp, 8'h00); end
    checks++; if ({bus.o_upd, bus.o_err, bus.o_frame} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want %b", {bus.o_upd, bus.o_err, bus.o_frame}, 3'b000); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state_q, ST_IDLE); end
    do_reset();
  endtask

  task automatic test_capture();
    do_reset();
    hold(8'hFE, 8'h03, 10);
    checks++; if (n_upd !== 1) begin errors++; $display("FAIL cap_upd_count got %0d want %0d", n_upd, 1); end
    checks++; if (first_upd !== 5) begin errors++; $display("FAIL cap_latency got %0d want %0d", first_upd, 5); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL cap_err got %0d want %0d", n_err, 0); end
    checks++; if (bus.o_digits[3:0] !== 4'h0) begin errors++; $display("FAIL cap_digit0 got %h want %h", bus.o_digits[3:0], 4'h0); end
    checks++; if (bus.o_valid !== 8'h01) begin errors++; $display("FAIL cap_valid got %h want %h", bus.o_valid, 8'h01); end
    checks++; if (bus.o_dp[0] !== 1'b0) begin errors++; $display("FAIL cap_dp0 got %b want %b", bus.o_dp[0], 1'b0); end
  endtask

  task automatic test_short_dwell();
    do_reset();
    hold(8'hFD, 8'h9E, 3);
    hold(8'hFF, 8'hFF, 6);
    checks++; if (n_upd !== 0) begin errors++; $display("FAIL short_upd got %0d want %0d", n_upd, 0); end
    checks++; if (bus.o_valid !== 8'h00) begin errors++; $display("FAIL short_valid got %h want %h", bus.o_valid, 8'h00); end
  endtask

  task automatic test_illegal();
    do_reset();
    hold(8'hFB, 8'h49, 6);
    checks++; if (bus.o_digits[11:8] !== 4'h5) begin errors++; $display("FAIL ill_pre_digit got %h want %h", bus.o_digits[11:8], 4'h5); end
    clear_stats();
    hold(8'hFB, 8'hFF, 6);
    checks++; if (n_upd !== 1 || n_both !== 1) begin errors++; $display("FAIL ill_pulses got upd=%0d both=%0d want 1 1", n_upd, n_both); end
    checks++; if (bus.o_valid[2] !== 1'b0) begin errors++; $display("FAIL ill_valid2 got %b want %b", bus.o_valid[2], 1'b0); end
    checks++; if (bus.o_digits[11:8] !== 4'h5) begin errors++; $display("FAIL ill_digit_kept got %h want %h", bus.o_digits[11:8], 4'h5); end
    checks++; if (bus.o_dp[2] !== 1'b0) begin errors++; $display("FAIL ill_dp2 got %b want %b", bus.o_dp[2], 1'b0); end
  endtask

  task automatic test_multi_sel();
    do_reset();
    hold(8'hFC, 8'h03, 10);
    checks++; if (n_upd !== 0) begin errors++; $display("FAIL multi_upd got %0d want %0d", n_upd, 0); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL multi_state got %0d want %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_frame();
    logic [7:0] s;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      s = ~(8'(1) << k);
      hold(s, pats[7 - k], 5);
    end
    hold(8'hFF, 8'hFF, 2);
    checks++; if (n_upd !== 8) begin errors++; $display("FAIL frame_upd got %0d want %0d", n_upd, 8); end
    checks++; if (n_frame !== 1) begin errors++; $display("FAIL frame_count got %0d want %0d", n_frame, 1); end
    checks++; if (frame_at_upd !== 8) begin errors++; $display("FAIL frame_position got %0d want %0d", frame_at_upd, 8); end
    checks++; if (bus.o_digits !== 32'h01234567) begin errors++; $display("FAIL frame_digits got %h want %h", bus.o_digits, 32'h01234567); end
    checks++; if (bus.o_valid !== 8'hFF) begin errors++; $display("FAIL frame_valid got %h want %h", bus.o_valid, 8'hFF); end
    checks++; if (bus.o_dp !== 8'h00) begin errors++; $display("FAIL frame_dp got %h want %h", bus.o_dp, 8'h00); end
    // Re-capture digit 0 with value 0 and dp lit: value updates, no frame.
    clear_stats();
    hold(8'hFE, 8'h02, 6);
    checks++; if (n_upd !== 1 || n_frame !== 0) begin errors++; $display("FAIL recap_pulses got upd=%0d frame=%0d want 1 0", n_upd, n_frame); end
    checks++; if (bus.o_digits !== 32'h01234560) begin errors++; $display("FAIL recap_digits got %h want %h", bus.o_digits, 32'h01234560); end
    checks++; if (bus.o_dp !== 8'h01) begin errors++; $display("FAIL recap_dp got %h want %h", bus.o_dp, 8'h01); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold(8'hFE, 8'h9F, 3);
    rst = 1'b1;
    #1;
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL mid_state got %0d want %0d", dut.state_q, ST_IDLE); end
    checks++; if (bus.o_digits !== 32'h0 || bus.o_valid !== 8'h0 || bus.o_upd !== 1'b0) begin errors++; $display("FAIL mid_outputs got %h %h %b want 0", bus.o_digits, bus.o_valid, bus.o_upd); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
    hold(8'hFE, 8'h9F, 10);
    checks++; if (first_upd !== 5) begin errors++; $display("FAIL mid_latency got %0d want %0d", first_upd, 5); end
    checks++; if (n_upd !== 1) begin errors++; $display("FAIL mid_upd got %0d want %0d", n_upd, 1); end
    checks++; if (nonzero_pre !== 0) begin errors++; $display("FAIL mid_zero_before got %0d want %0d", nonzero_pre, 0); end
    checks++; if (bus.o_digits !== 32'h1 || bus.o_valid !== 8'h01) begin errors++; $display("FAIL mid_result got %h %h want %h %h", bus.o_digits, bus.o_valid, 32'h1, 8'h01); end
  endtask

  initial begin
    pats[0] = 8'h03; pats[1] = 8'h9F; pats[2] = 8'h25; pats[3] = 8'h0D;
    pats[4] = 8'h99; pats[5] = 8'h49; pats[6] = 8'h41; pats[7] = 8'h1F;
    clear_stats();
    test_reset();
    test_capture();
    test_short_dwell();
    test_illegal();
    test_multi_sel();
    test_frame();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_rx.md
SEG_SCAN_RX -- requirements
Module: seg_scan_rx

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4, legal range 2..255: consecutive identical input cycles required before a capture.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_seg  input  8  active-low segment bus; bit7=a, 6=b, 5=c, 4=d, 3=e, 2=f, 1=g, 0=dp.
REQ-005 SHALL have port i_sel  input  8  active-low digit enable; bit k=0 selects digit k.
REQ-006 SHALL have port o_digits  output  32  decoded hex values; digit k at bits [4k+3:4k].
REQ-007 SHALL have port o_valid  output  8  bit k=1 when digit k holds a legally decoded value.
REQ-008 SHALL have port o_dp  output  8  captured decimal point of digit k, active-high (1 = lit).
REQ-009 SHALL have port o_upd  output  1  one-cycle pulse on every capture.
REQ-010 SHALL have port o_err  output  1  one-cycle pulse on a capture whose segment pattern is illegal.
REQ-011 SHALL have port o_frame  output  1  one-cycle pulse when all 8 digits have been captured since the previous frame.

Function
REQ-012 SHALL register {i_sel, i_seg} once (r_in) before any other use; inputs are synchronous to clk.
REQ-013 SHALL treat r_in as selecting a digit only when exactly one bit of r_sel is 0; zero or several 0 bits SHALL mean no selection.
REQ-014 SHALL implement FSM IDLE / DWELL / HELD: IDLE = no selection; DWELL = counting stability; HELD = captured, waiting for a change.
REQ-015 SHALL move to IDLE from any state whenever r_in has no selection, clearing the counter.
REQ-016 SHALL enter DWELL with counter=1 whenever r_in holds a valid selection that differs from the previous r_in, from any state.
REQ-017 SHALL in DWELL increment the counter while r_in is unchanged, and on the edge at which the counter reaches STABLE_CYC SHALL capture and go to HELD.
REQ-018 SHALL in HELD perform no further captures until r_in changes.
REQ-019 SHALL make capture outputs visible STABLE_CYC+1 edges after inputs change and are then held constant.
REQ-020 SHALL on capture decode r_seg[7:1] per table: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-021 SHALL on legal capture write digit k, set o_valid[k]=1, write o_dp[k]=~r_seg[0], and pulse o_upd.
REQ-022 SHALL on illegal capture keep digit k's value, clear o_valid[k], still write o_dp[k], and pulse o_upd and o_err together.
REQ-023 SHALL keep an 8-bit seen mask, set bit k on every capture of digit k; when the mask becomes 0xFF, SHALL pulse o_frame on that same capture edge and clear the mask to 0x00.
REQ-024 SHALL let a repeated capture of an already-seen digit update the value without affecting o_frame.

Reset
REQ-025 SHALL on rst=1 immediately set o_digits=0, o_valid=0, o_dp=0, o_upd=0, o_err=0, o_frame=0, counter=0, mask=0, r_in=16'hFFFF, and state=IDLE.
REQ-026 SHALL abandon any dwell in progress on reset mid-operation; the first capture after release needs a full STABLE_CYC dwell.

Structure
REQ-027 SHALL take the segment-pattern constants and the FSM state encoding from shared package seg_pkg, which the display driver also uses.
REQ-028 SHALL place decoding in combinational sub-module seg_decode7 (in: 7-bit pattern; out: 4-bit value, legal flag).

Verification
REQ-029 SHALL hold sel=8'hFE, seg=8'h03 for 10 cycles with STABLE_CYC=4 -> a single o_upd, digits[3:0]=0, valid[0]=1, dp[0]=0.
REQ-030 SHALL hold sel=8'hFD, seg=8'h9E for exactly 3 cycles, then change it -> no capture, o_upd stays 0.
REQ-031 SHALL hold sel=8'hFB, seg=8'hFF (blank) for 6 cycles -> o_upd and o_err pulse together, valid[2]=0, digits[11:8] unchanged.
REQ-032 SHALL hold sel=8'hFC, seg=8'h03 for 10 cycles -> no capture, FSM stays IDLE.
REQ-033 SHALL scan digits 0..7 with patterns for 7,6,...,0, each held 5 cycles -> o_frame pulses once, on the digit-7 capture, then o_digits=32'h01234567 and valid=8'hFF.
REQ-034 SHALL assert rst at count 2 of a dwell, release it, and hold the same input -> capture only after a full 4-cycle dwell, with all outputs 0 in between.
